column_mult_seq: RTL and testbench
==================================

COLUMN_MULT_SEQ -- requirements
Module: column_mult_seq

Interface
REQ-001 Parameter SIZE, default 4: number of 32-bit IEEE-754 binary32 cells per column.
REQ-002 Parameter LANES, default 2: number of fp32 multipliers working in parallel; SIZE SHALL be a multiple of LANES (elaboration error otherwise).
REQ-003 Parameter CELL_WIDTH, default 32: fixed at 32; any other value SHALL be an elaboration error.
REQ-004 in_clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 in_reset  input  1  asynchronous, active-low reset.
REQ-006 in_a  input  SIZE*32  operand column; cell i occupies bits [32i+31:32i].
REQ-007 in_b  input  SIZE*32  operand column, same cell layout.
REQ-008 in_mode  input  1  0 = elementwise (c[i]=a[i]*b[i]); 1 = scale (c[i]=a[i]*b[0]).
REQ-009 in_ready  input  1  operands valid; request to start.
REQ-010 out_ack  input  1  consumer has taken out_c.
REQ-011 out_busy  output  1  high in BUSY.
REQ-012 out_ready  output  1  high in DONE; out_c valid.
REQ-013 out_c  output  SIZE*32  result column, same cell layout.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE with in_ready=1 at an edge: capture in_a, in_b, in_mode into internal registers, clear beat counter, go BUSY.
REQ-016 Input changes after capture SHALL NOT affect the operation in progress.
REQ-017 BUSY: each edge computes cells beat*LANES .. beat*LANES+LANES-1 into a work register and increments the beat counter.
REQ-018 After beat SIZE/LANES-1 completes, go DONE; out_c loads the work register on that same edge, so out_ready rises exactly SIZE/LANES edges after the capture edge.
REQ-019 in_ready SHALL be ignored in BUSY and DONE.
REQ-020 DONE: out_ready and out_c hold until an edge with out_ack=1; then IDLE, out_ready=0, out_c holds its last value.
REQ-021 in_ready=1 together with out_ack=1 in DONE: ack honoured, go IDLE; the new request is accepted at the next edge only if in_ready is still 1.
REQ-022 out_ack outside DONE SHALL have no effect.
REQ-023 Product sign = sign(a) xor sign(b); mantissa product 24x24 bits; rounding round-to-nearest-even.
REQ-024 Subnormal inputs and results SHALL be flushed to signed zero.
REQ-025 Exponent overflow after rounding SHALL give signed infinity.
REQ-026 Any NaN input, or inf*zero, SHALL give canonical NaN 0x7FC00000; inf*finite-nonzero SHALL give signed infinity.

Reset
REQ-027 in_reset=0 SHALL immediately force IDLE, out_busy=0, out_ready=0, out_c=0, and clear beat counter, work and capture registers, regardless of clock.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the operation with no partial result visible; the first request after release starts a fresh operation.

Structure
REQ-029 Package column_pkg SHALL hold the FSM state encoding, FP32 field constants (bias 127, exponent all-ones, canonical NaN 0x7FC00000), and the CELL_WIDTH constant.
REQ-030 Sub-module fp32_mul (combinational binary32 multiplier implementing REQ-023..026) SHALL be instantiated LANES times; per-beat operand selection is muxed in column_mult_seq.

Verification
REQ-031 SIZE=2, LANES=1, mode 0, a={0x40000000,0x3FC00000}, b={0x40400000,0xC0000000} (cell0 first) -> out_c={0x40C00000,0xC0400000}; out_ready rises 2 edges after capture.
REQ-032 SIZE=4, LANES=2, mode 1, a={2.0,3.0,-1.0,0.5}, b[0]=2.0 -> out_c={0x40800000,0x40C00000,0xC0000000,0x3F800000}; latency 2 edges.
REQ-033 Specials: 0x7F800000*0x00000000 -> 0x7FC00000; 0x7F000000*0x7F000000 -> 0x7F800000; 0x00400000*0x3F800000 -> 0x00000000; 0xFF800000*0x40000000 -> 0xFF800000.
REQ-034 Hold out_ack=0 in DONE for 10 cycles while changing in_a and pulsing in_ready -> out_c and out_ready stable, no new capture; then in_ready=1 and out_ack=1 together -> IDLE on that edge, capture on the next edge.
REQ-035 Assert in_reset=0 mid-BUSY between clock edges -> outputs 0 immediately; after release, a new request yields the correct result with full latency.
REQ-036 SIZE=8, LANES=8 -> result in 1 edge; SIZE=8, LANES=1 -> 8 edges; both bit-identical to a reference model over 1000 random vectors.

Source files
------------

// File: rtl/column_pkg.sv
// Shared definitions for the column multiplier: controller state encoding
// and binary32 field constants.
package column_pkg;

    localparam int          CELL_WIDTH = 32;
    localparam int          FP_BIAS    = 127;
    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fp32_mul.sv
// Combinational binary32 multiplier: round-to-nearest-even, subnormals
// flushed to signed zero, canonical NaN for invalid operations.
module fp32_mul
    import column_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);
    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0] prod;
    logic        norm;
    logic [22:0] frac_pre;
    logic        guard, sticky, rnd;
    logic        carry;
    logic [22:0] frac;
    logic [9:0]  exp_sum;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        fa     = a[22:0];
        fb     = b[22:0];
        nan_a  = (ea == FP_EXP_MAX) && (fa != '0);
        nan_b  = (eb == FP_EXP_MAX) && (fb != '0);
        inf_a  = (ea == FP_EXP_MAX) && (fa == '0);
        inf_b  = (eb == FP_EXP_MAX) && (fb == '0);
        zero_a = (ea == '0);
        zero_b = (eb == '0);

        prod = 48'({1'b1, fa}) * 48'({1'b1, fb});
        norm = prod[47];
        // Product of two [1,2) significands lies in [1,4); shift by one when >= 2.
        if (norm) begin
            frac_pre = prod[46:24];
            guard    = prod[23];
            sticky   = |prod[22:0];
        end else begin
            frac_pre = prod[45:23];
            guard    = prod[22];
            sticky   = |prod[21:0];
        end
        rnd           = guard & (sticky | frac_pre[0]);
        {carry, frac} = {1'b0, frac_pre} + 24'(rnd);

        // Biased exponent is exp_sum - FP_BIAS; kept unsigned to avoid sign handling.
        exp_sum = 10'(ea) + 10'(eb) + 10'(norm) + 10'(carry);

        c = {sign, exp_sum[7:0] - 8'(FP_BIAS), frac};
        if (nan_a || nan_b) begin
            c = FP_QNAN;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            c = FP_QNAN;
        end else if (inf_a || inf_b) begin
            c = {sign, FP_EXP_MAX, 23'd0};
        end else if (zero_a || zero_b) begin
            c = {sign, 31'd0};
        end else if (exp_sum >= 10'(FP_BIAS + 255)) begin
            c = {sign, FP_EXP_MAX, 23'd0};
        end else if (exp_sum <= 10'(FP_BIAS)) begin
            c = {sign, 31'd0};
        end
    end

endmodule

// File: rtl/column_mult_seq.sv
// Sequential column multiplier: captures two fp32 columns and multiplies
// LANES cells per clock, elementwise or scaled by cell 0 of in_b.
module column_mult_seq
    import column_pkg::*;
#(
    parameter int SIZE       = 4,
    parameter int LANES      = 2,
    parameter int CELL_WIDTH = 32
) (
    input  logic                       in_clk,
    input  logic                       in_reset,
    input  logic [SIZE*CELL_WIDTH-1:0] in_a,
    input  logic [SIZE*CELL_WIDTH-1:0] in_b,
    input  logic                       in_mode,
    input  logic                       in_ready,
    input  logic                       out_ack,
    output logic                       out_busy,
    output logic                       out_ready,
    output logic [SIZE*CELL_WIDTH-1:0] out_c,
    output state_t                     dbg_state
);
    localparam int COL_W  = SIZE * CELL_WIDTH;
    localparam int BEATS  = SIZE / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    if (SIZE % LANES != 0) begin : g_bad_lanes
        $error("column_mult_seq: SIZE must be a multiple of LANES");
    end
    if (CELL_WIDTH != column_pkg::CELL_WIDTH) begin : g_bad_width
        $error("column_mult_seq: CELL_WIDTH must be 32");
    end

    // Handshake: a request is taken on any edge in IDLE with in_ready=1; the
    // result is offered while out_ready=1 and retired on an edge with out_ack=1.
    state_t                           state, state_next;
    logic [COL_W-1:0]                 a_q, b_q, work, work_next;
    logic                             mode_q;
    logic [BEAT_W-1:0]                beat;
    logic                             last_beat;
    logic [LANES-1:0][CELL_WIDTH-1:0] lane_a, lane_b, lane_c;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = a_q[(int'(beat) * LANES + l) * CELL_WIDTH +: CELL_WIDTH];
            lane_b[l] = mode_q ? b_q[CELL_WIDTH-1:0]
                               : b_q[(int'(beat) * LANES + l) * CELL_WIDTH +: CELL_WIDTH];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        fp32_mul u_mul (
            .a(lane_a[l]),
            .b(lane_b[l]),
            .c(lane_c[l])
        );
    end

    always_comb begin
        work_next = work;
        for (int l = 0; l < LANES; l++) begin
            work_next[(int'(beat) * LANES + l) * CELL_WIDTH +: CELL_WIDTH] = lane_c[l];
        end
    end

    always_comb begin
        state_next = state;
        out_busy   = 1'b0;
        out_ready  = 1'b0;
        last_beat  = (beat == LAST_BEAT);
        unique case (state)
            ST_IDLE: if (in_ready) state_next = ST_BUSY;
            ST_BUSY: begin
                out_busy = 1'b1;
                if (last_beat) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_ready = 1'b1;
                if (out_ack) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            beat   <= '0;
            work   <= '0;
            out_c  <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: if (in_ready) begin
                    a_q    <= in_a;
                    b_q    <= in_b;
                    mode_q <= in_mode;
                    beat   <= '0;
                end
                ST_BUSY: begin
                    work <= work_next;
                    beat <= last_beat ? '0 : beat + 1'b1;
                    // The final beat's cells go straight to out_c alongside work.
                    if (last_beat) out_c <= work_next;
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_column_mult_seq.sv
// Bench for column_mult_seq: four configurations share one stimulus bus and
// are checked against an independent fp32 model and hand-computed vectors.
`timescale 1ns/1ps
module tb_column_mult_seq;
    import column_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [255:0] a_bus = '0, b_bus = '0;
    logic         mode = 1'b0, req = 1'b0, ack = 1'b0;

    logic [63:0]  c2;
    logic [127:0] c4;
    logic [255:0] c8w, c8n;
    logic         b2, b4, b8w, b8n, r2, r4, r8w, r8n;
    state_t       st2, st4, st8w, st8n;
    logic [3:0]   busy, ready;

    assign busy  = {b8n, b8w, b4, b2};
    assign ready = {r8n, r8w, r4, r2};

    column_mult_seq #(.SIZE(2), .LANES(1)) u_d2 (
        .in_clk(clk), .in_reset(rst_n), .in_a(a_bus[63:0]), .in_b(b_bus[63:0]),
        .in_mode(mode), .in_ready(req), .out_ack(ack), .out_busy(b2),
        .out_ready(r2), .out_c(c2), .dbg_state(st2));
    column_mult_seq #(.SIZE(4), .LANES(2)) u_d4 (
        .in_clk(clk), .in_reset(rst_n), .in_a(a_bus[127:0]), .in_b(b_bus[127:0]),
        .in_mode(mode), .in_ready(req), .out_ack(ack), .out_busy(b4),
        .out_ready(r4), .out_c(c4), .dbg_state(st4));
    column_mult_seq #(.SIZE(8), .LANES(8)) u_d8w (
        .in_clk(clk), .in_reset(rst_n), .in_a(a_bus), .in_b(b_bus),
        .in_mode(mode), .in_ready(req), .out_ack(ack), .out_busy(b8w),
        .out_ready(r8w), .out_c(c8w), .dbg_state(st8w));
    column_mult_seq #(.SIZE(8), .LANES(1)) u_d8n (
        .in_clk(clk), .in_reset(rst_n), .in_a(a_bus), .in_b(b_bus),
        .in_mode(mode), .in_ready(req), .out_ack(ack), .out_busy(b8n),
        .out_ready(r8n), .out_c(c8n), .dbg_state(st8n));

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [255:0] exp_q[$];
    logic [127:0] last_c4;
    logic [63:0]  last_c2;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int cfg_size(input int k);
        case (k)
            0: return 2;
            1: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_lat(input int k);
        case (k)
            0: return 2;
            1: return 2;
            2: return 1;
            default: return 8;
        endcase
    endfunction

    function automatic logic [255:0] get_c(input int k);
        case (k)
            0: return {192'd0, c2};
            1: return {128'd0, c4};
            2: return c8w;
            default: return c8n;
        endcase
    endfunction

    // Reference fp32 multiply via exact integer product and remainder rounding.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        bit s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 0);
        b_nan  = (eb == 255) && (b[22:0] != 0);
        a_inf  = (ea == 255) && (a[22:0] == 0);
        b_inf  = (eb == 255) && (b[22:0] == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan) return 32'h7FC00000;
        if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC00000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        ma = 64'(a[22:0]) + (64'd1 << 23);
        mb = 64'(b[22:0]) + (64'd1 << 23);
        p  = ma * mb;
        e  = ea + eb - 127;
        sh = 23;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [255:0] col_ref(input logic [255:0] a, input logic [255:0] b,
                                             input logic m, input int n);
        logic [255:0] c;
        c = '0;
        for (int i = 0; i < n; i++)
            c[i*32 +: 32] = ref_mul(a[i*32 +: 32], m ? b[31:0] : b[i*32 +: 32]);
        return c;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return r;
            1: return {r[31], 8'h00, r[22:0]};
            2: return {r[31], 8'hFF, (r[0] ? 23'd0 : r[22:0])};
            default: return {r[31], 8'($urandom_range(64, 190)), r[22:0]};
        endcase
    endfunction

    function automatic logic [255:0] rnd_col();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = rnd_fp();
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic m,
                          input string tag);
        int lat[4];
        logic [255:0] e;
        for (int k = 0; k < 4; k++) exp_q.push_back(col_ref(a, b, m, cfg_size(k)));
        @(negedge clk);
        a_bus = a; b_bus = b; mode = m; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        a_bus = rnd_col(); b_bus = rnd_col(); mode = ~m;
        for (int k = 0; k < 4; k++) lat[k] = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (ready == 4'hF) break;
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) if (ready[k] && lat[k] == 0) lat[k] = cyc;
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s lat d%0d", tag, k), 256'(lat[k]), 256'(cfg_lat(k)));
            e = exp_q.pop_front();
            check($sformatf("%s c d%0d", tag, k), get_c(k), e);
        end
        last_c4 = c4;
        last_c2 = c2;
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        check($sformatf("%s ack", tag), 256'(ready), 256'(0));
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         mode;
        logic [127:0] exp;
    } vec_t;
    vec_t tbl[4];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [255:0] ha, hb, ha2, hb2, e_hold, e_next;
        tbl[0] = '{a: {32'h7F000000, 32'h7F800000, 32'h3FC00000, 32'h40000000},
                   b: {32'h7F000000, 32'h00000000, 32'hC0000000, 32'h40400000},
                   mode: 1'b0,
                   exp: {32'h7F800000, 32'h7FC00000, 32'hC0400000, 32'h40C00000}};
        tbl[1] = '{a: {32'h3F800000, 32'h7FA00000, 32'hFF800000, 32'h00400000},
                   b: {32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F800000},
                   mode: 1'b0,
                   exp: {32'h3F800000, 32'h7FC00000, 32'hFF800000, 32'h00000000}};
        tbl[2] = '{a: {32'h3F000000, 32'hBF800000, 32'h40400000, 32'h40000000},
                   b: {32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h40000000},
                   mode: 1'b1,
                   exp: {32'h3F800000, 32'hC0000000, 32'h40C00000, 32'h40800000}};
        tbl[3] = '{a: {32'h7F7FFFFF, 32'h80000000, 32'h3F800001, 32'h3F800001},
                   b: {32'h3F800001, 32'h3F800000, 32'h3FC00000, 32'h3F800001},
                   mode: 1'b0,
                   exp: {32'h7F800000, 32'h80000000, 32'h3FC00002, 32'h3F800002}};

        // Reset state
        #1;
        check("rst busy", 256'(busy), 256'(0));
        check("rst ready", 256'(ready), 256'(0));
        check("rst c4", 256'(c4), 256'(0));
        check("rst state", 256'(st4), 256'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_op({$urandom, $urandom, $urandom, $urandom, tbl[i].a},
                   {$urandom, $urandom, $urandom, $urandom, tbl[i].b},
                   tbl[i].mode, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d const d4", i), 256'(last_c4), 256'(tbl[i].exp));
            check($sformatf("tbl%0d const d2", i), 256'(last_c2), 256'(tbl[i].exp[63:0]));
        end

        // out_ack in IDLE is ignored and out_c keeps the last result
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        check("idle ack busy", 256'(busy | ready), 256'(0));
        check("idle ack c4", 256'(c4), 256'(last_c4));

        // DONE holds through input churn; ack+req together returns to IDLE
        ha = rnd_col(); hb = rnd_col();
        e_hold = col_ref(ha, hb, 1'b0, 4);
        @(negedge clk); a_bus = ha; b_bus = hb; mode = 1'b0; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        repeat (9) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); a_bus = rnd_col(); req = i[0]; ack = 1'b0;
            @(posedge clk); #1;
            check($sformatf("hold ready %0d", i), 256'(ready), 256'(4'hF));
            check($sformatf("hold c4 %0d", i), 256'(c4), e_hold);
        end
        ha2 = rnd_col(); hb2 = rnd_col();
        e_next = col_ref(ha2, hb2, 1'b1, 8);
        @(negedge clk); a_bus = ha2; b_bus = hb2; mode = 1'b1; req = 1'b1; ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;
        check("ack+req idle", 256'(busy | ready), 256'(0));
        check("ack+req state", 256'(st4), 256'(ST_IDLE));
        @(posedge clk); #1; req = 1'b0;
        check("ack+req capture", 256'(busy), 256'(4'hF));
        repeat (8) @(posedge clk);
        #1;
        check("ack+req ready", 256'(ready), 256'(4'hF));
        check("ack+req c8n", c8n, e_next);
        check("ack+req c4", 256'(c4), 256'(e_next[127:0]));
        @(negedge clk); ack = 1'b1;
        @(posedge clk); #1; ack = 1'b0;

        // Reset between edges while BUSY
        @(negedge clk); a_bus = rnd_col(); b_bus = rnd_col(); mode = 1'b0; req = 1'b1;
        @(posedge clk); #1; req = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid rst busy", 256'(busy), 256'(0));
        check("mid rst ready", 256'(ready), 256'(0));
        for (int k = 0; k < 4; k++) check($sformatf("mid rst c d%0d", k), get_c(k), 256'(0));
        check("mid rst state", 256'(st8n), 256'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(rnd_col(), rnd_col(), 1'b0, "post rst");

        // Random vectors against the reference model
        for (int i = 0; i < 1000; i++)
            run_op(rnd_col(), rnd_col(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
